latch_gate_arbiter: RTL and testbench
=====================================

LATCH_GATE_ARBITER -- requirements
Module: latch_gate_arbiter

Interface
REQ-001 Parameter GATE_CYCLES, default 2, range 1..15: gate-high pulse width in clocks.
REQ-002 Parameter NLATCH, default 8, fixed: number of gated R/S latches controlled.
REQ-003 sysclk  input  1  the single clock; all state changes on its rising edge.
REQ-004 sys_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req  input  4  per-requester operation request, level, held until matching ack.
REQ-006 op  input  4  per-requester operation: 1 = set latch, 0 = reset latch.
REQ-007 idx  input  4x3 (12 bits, requester k at [3k+2:3k])  target latch index.
REQ-008 clear_all  input  1  level request to reset all latches.
REQ-009 ack  output  4  one-cycle completion pulse, one-hot to the granted requester.
REQ-010 clr_done  output  1  one-cycle pulse on clear_all completion.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 latch_s  output  8  per-latch S drive.
REQ-013 latch_r  output  8  per-latch R drive.
REQ-014 latch_g  output  8  per-latch gate enable.

Function
REQ-015 The FSM states shall be IDLE, SETUP, GATE, HOLD, DONE; all outputs registered.
REQ-016 In IDLE, clear_all high shall take priority over req and start a clear sequence; otherwise any req bit high shall start an operation for the round-robin winner.
REQ-017 Round-robin: after a grant to requester k, priority order shall be k+1, k+2, k+3, k (mod 4).
REQ-018 Winner, op, and idx shall be captured in the IDLE->SETUP transition; later changes on req/op/idx shall be ignored until DONE.
REQ-019 SETUP (1 cycle): S or R of the target latch driven, gate low.
REQ-020 GATE (GATE_CYCLES cycles): S/R unchanged, gate of target latch high.
REQ-021 HOLD (1 cycle): gate low, S/R still driven.
REQ-022 DONE (1 cycle): S/R/gate all low, ack[winner] (or clr_done) high; next state IDLE.
REQ-023 Latency: req sampled in IDLE at cycle 0 gives ack at cycle GATE_CYCLES+3 (cycle 5 for default); back-to-back operations start no earlier than one IDLE cycle after DONE.
REQ-024 latch_s and latch_r for the same latch shall never be high together (S=R=1 is forbidden).
REQ-025 Clear sequence: identical timing with latch_r = all ones, latch_g pulsed on all 8 latches, latch_s = 0.
REQ-026 Request withdrawn before ack: operation still completes and ack still pulses.
REQ-027 clear_all asserted mid-operation: current operation completes; clear runs from the next IDLE.
REQ-028 Requester whose req stays high after its ack shall be rescheduled by round-robin only.

Reset
REQ-029 sys_rst_n low shall force IDLE, all outputs 0, round-robin pointer to requester 0 highest priority, immediately and independent of sysclk.
REQ-030 Reset during GATE shall drop latch_g at once; no ack for the aborted operation.

Structure
REQ-031 State encoding, NLATCH, and requester count shall reside in shared package dga_pkg.
REQ-032 Round-robin selection shall be a sub-module rr_arb4 (req[3:0], pointer in, one-hot grant out, combinational).
REQ-033 The phase counter shall be 4 bits, reloaded on SETUP->GATE.

Verification
REQ-034 Bench: reset release, req=0001, op[0]=1, idx0=5 -> latch_s=0x20 cycles 1-4, latch_g=0x20 cycles 2-3, ack=0001 cycle 5.
REQ-035 Bench: req=1111 held constant -> acks in order 0,1,2,3,0.
REQ-036 Bench: clear_all and req=0010 together in IDLE -> latch_r=0xFF and latch_g=0xFF pulsed first, then clr_done, then requester 1 served.
REQ-037 Bench: req[2] dropped in GATE -> ack=0100 still at cycle 5.
REQ-038 Bench: sys_rst_n low in GATE -> latch_g=0 immediately, no ack; after release, pointer back to requester 0.
REQ-039 Bench: GATE_CYCLES=1 -> ack at cycle 4; assertion check that latch_s & latch_r is never nonzero.

Source files
------------

// File: rtl/dga_pkg.sv
// Shared types and constants for the gated R/S latch arbiter.
// State encoding, latch count and requester count live here.
package dga_pkg;

  localparam int N_LATCH = 8;
  localparam int N_REQ   = 4;
  localparam int IDXW    = 3;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    GATE,
    HOLD,
    DONE
  } state_t;

  function automatic logic [N_LATCH-1:0] latch_onehot(
    input logic [IDXW-1:0] i
  );
    logic [N_LATCH-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arb4.sv
// Four-way round-robin picker: ptr names the highest-priority
// requester, grant is one-hot (or zero when nobody asks).
module rr_arb4
  import dga_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       ptr,
  output logic [N_REQ-1:0] grant
);

  // Walk from lowest to highest priority so the nearest-to-ptr wins.
  always_comb begin
    grant = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[ptr + 2'(i)]) begin
        grant = 4'b0001 << (ptr + 2'(i));
      end
    end
  end

endmodule

// File: rtl/latch_gate_arbiter.sv
// Arbitrates set/reset/clear operations onto eight gated R/S latches
// with a SETUP / GATE / HOLD / DONE pulse sequence.
module latch_gate_arbiter
  import dga_pkg::*;
#(
  parameter int GATE_CYCLES = 2,
  parameter int NLATCH      = N_LATCH
) (
  input  logic              sysclk,
  input  logic              sys_rst_n,
  input  logic [3:0]        req,
  input  logic [3:0]        op,
  input  logic [11:0]       idx,
  input  logic              clear_all,
  output logic [3:0]        ack,
  output logic              clr_done,
  output logic              busy,
  output logic [NLATCH-1:0] latch_s,
  output logic [NLATCH-1:0] latch_r,
  output logic [NLATCH-1:0] latch_g
);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [3:0]        win_q, win_d;
  logic              op_q, op_d;
  logic [IDXW-1:0]   li_q, li_d;
  logic              clr_q, clr_d;

  logic [3:0]        ack_q, ack_d;
  logic              clr_done_q, clr_done_d;
  logic              busy_q, busy_d;
  logic [NLATCH-1:0] s_q, s_d;
  logic [NLATCH-1:0] r_q, r_d;
  logic [NLATCH-1:0] g_q, g_d;
  logic [NLATCH-1:0] oh;

  logic [3:0]        grant;
  logic [1:0]        gidx;

  rr_arb4 u_rr (
    .req   (req),
    .ptr   (ptr_q),
    .grant (grant)
  );

  always_comb begin
    gidx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant[k]) gidx = 2'(k);
    end
  end

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
      op_q    <= 1'b0;
      li_q    <= '0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      op_q    <= op_d;
      li_q    <= li_d;
      clr_q   <= clr_d;
    end
  end

  // Operands are captured only on leaving IDLE; inputs are ignored after.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    op_d    = op_q;
    li_d    = li_q;
    clr_d   = clr_q;
    unique case (state_q)
      IDLE: begin
        if (clear_all) begin
          state_d = SETUP;
          clr_d   = 1'b1;
          win_d   = '0;
        end else if (|req) begin
          state_d = SETUP;
          clr_d   = 1'b0;
          win_d   = grant;
          op_d    = op[gidx];
          li_d    = idx[IDXW*gidx +: IDXW];
          ptr_d   = gidx + 2'd1;
        end
      end
      SETUP: begin
        state_d = GATE;
        cnt_d   = 4'(GATE_CYCLES - 1);
      end
      GATE: begin
        if (cnt_q == 4'd0) state_d = HOLD;
        else cnt_d = cnt_q - 4'd1;
      end
      HOLD:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode the upcoming state so they are registered alongside it.
  always_comb begin
    ack_d      = '0;
    clr_done_d = 1'b0;
    busy_d     = (state_d != IDLE);
    s_d        = '0;
    r_d        = '0;
    g_d        = '0;
    oh         = latch_onehot(li_d);
    unique case (state_d)
      SETUP, GATE, HOLD: begin
        if (clr_d)     r_d = '1;
        else if (op_d) s_d = oh;
        else           r_d = oh;
        if (state_d == GATE) g_d = clr_d ? '1 : oh;
      end
      DONE: begin
        if (clr_d) clr_done_d = 1'b1;
        else       ack_d      = win_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ack_q      <= '0;
      clr_done_q <= 1'b0;
      busy_q     <= 1'b0;
      s_q        <= '0;
      r_q        <= '0;
      g_q        <= '0;
    end else begin
      ack_q      <= ack_d;
      clr_done_q <= clr_done_d;
      busy_q     <= busy_d;
      s_q        <= s_d;
      r_q        <= r_d;
      g_q        <= g_d;
    end
  end

  assign ack      = ack_q;
  assign clr_done = clr_done_q;
  assign busy     = busy_q;
  assign latch_s  = s_q;
  assign latch_r  = r_q;
  assign latch_g  = g_q;

endmodule

// File: tb/tb_latch_gate_arbiter.sv
// Bench for latch_gate_arbiter: two instances (GATE_CYCLES 2 and 1)
// share stimulus and are compared against a transaction-level model.
module tb_latch_gate_arbiter;

  localparam int G0 = 2;
  localparam int G1 = 1;

  logic        sysclk    = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [3:0]  req       = '0;
  logic [3:0]  op        = '0;
  logic [11:0] idx       = '0;
  logic        clear_all = 1'b0;

  logic [3:0]  ack0, ack1;
  logic        cd0, cd1, busy0, busy1;
  logic [7:0]  s0, r0, g0, s1, r1, g1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 sysclk = ~sysclk;

  latch_gate_arbiter #(.GATE_CYCLES(G0), .NLATCH(8)) u_dut0 (
    .sysclk    (sysclk),
    .sys_rst_n (sys_rst_n),
    .req       (req),
    .op        (op),
    .idx       (idx),
    .clear_all (clear_all),
    .ack       (ack0),
    .clr_done  (cd0),
    .busy      (busy0),
    .latch_s   (s0),
    .latch_r   (r0),
    .latch_g   (g0)
  );

  latch_gate_arbiter #(.GATE_CYCLES(G1), .NLATCH(8)) u_dut1 (
    .sysclk    (sysclk),
    .sys_rst_n (sys_rst_n),
    .req       (req),
    .op        (op),
    .idx       (idx),
    .clear_all (clear_all),
    .ack       (ack1),
    .clr_done  (cd1),
    .busy      (busy1),
    .latch_s   (s1),
    .latch_r   (r1),
    .latch_g   (g1)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: one transaction per instance, outputs derived from
  // the cycle offset d since the IDLE cycle in which it was sampled.
  int  cyc = 0;
  int  st[2];
  bit  act[2] = '{1'b0, 1'b0};
  int  win[2];
  bit  opv[2];
  int  idv[2];
  bit  clr[2];
  int  ptr[2] = '{0, 0};

  function automatic int gc(input int m);
    return (m == 0) ? G0 : G1;
  endfunction

  function automatic int pick(input int p, input logic [3:0] r);
    for (int i = 0; i < 4; i++) begin
      if (r[(p + i) % 4]) return (p + i) % 4;
    end
    return 0;
  endfunction

  function automatic int oh2i(input logic [3:0] a);
    for (int k = 0; k < 4; k++) if (a[k]) return k;
    return -1;
  endfunction

  function automatic logic [29:0] exp_out(input int m);
    int g = gc(m);
    int d = cyc - st[m];
    logic [7:0] oh, s, r, gt;
    logic [3:0] a;
    logic cd;
    oh = 8'h01 << idv[m];
    s = '0; r = '0; gt = '0; a = '0; cd = 1'b0;
    if (!act[m] || d < 1 || d > g + 3) return '0;
    if (d <= g + 2) begin
      if (clr[m]) r = 8'hFF;
      else if (opv[m]) s = oh;
      else r = oh;
    end
    if (d >= 2 && d <= g + 1) gt = clr[m] ? 8'hFF : oh;
    if (d == g + 3) begin
      if (clr[m]) cd = 1'b1;
      else a = 4'h1 << win[m];
    end
    return {1'b1, cd, a, s, r, gt};
  endfunction

  always @(posedge sysclk) cyc <= cyc + 1;

  always @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int m = 0; m < 2; m++) begin
        act[m] <= 1'b0;
        ptr[m] <= 0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (!act[m] || cyc >= st[m] + gc(m) + 4) begin
          if (clear_all) begin
            act[m] <= 1'b1;
            st[m]  <= cyc;
            clr[m] <= 1'b1;
          end else if (req != 4'b0) begin
            act[m] <= 1'b1;
            st[m]  <= cyc;
            clr[m] <= 1'b0;
            win[m] <= pick(ptr[m], req);
            opv[m] <= op[pick(ptr[m], req)];
            idv[m] <= int'(idx[3*pick(ptr[m], req) +: 3]);
            ptr[m] <= (pick(ptr[m], req) + 1) % 4;
          end
        end
      end
    end
  end

  always @(negedge sysclk) begin
    chk("out_g2", {2'b0, busy0, cd0, ack0, s0, r0, g0}, {2'b0, exp_out(0)});
    chk("out_g1", {2'b0, busy1, cd1, ack1, s1, r1, g1}, {2'b0, exp_out(1)});
    chk("sr_excl_g2", {24'b0, s0 & r0}, 32'h0);
    chk("sr_excl_g1", {24'b0, s1 & r1}, 32'h0);
  end

  task automatic nxt();
    @(negedge sysclk);
    #1;
  endtask

  task automatic do_reset();
    nxt();
    sys_rst_n = 1'b0;
    req = '0;
    clear_all = 1'b0;
    repeat (2) nxt();
    sys_rst_n = 1'b1;
  endtask

  int got[$];
  int order[$];

  initial begin
    int t0, d, a0, a1, na;
    bit fin;

    // Single set operation, latency on both gate widths.
    do_reset();
    nxt();
    req = 4'b0001; op = 4'b0001; idx = 12'd5;
    t0 = cyc; a0 = -1; a1 = -1;
    for (int n = 0; n < 10; n++) begin
      @(negedge sysclk);
      d = cyc - t0;
      if (ack0[0] && a0 < 0) a0 = d;
      if (ack1[0] && a1 < 0) a1 = d;
      if (d == 1) chk("t1_s_setup", {24'b0, s0}, 32'h20);
      if (d == 2) chk("t1_g_gate", {24'b0, g0}, 32'h20);
      if (d == 4) chk("t1_g_hold", {24'b0, g0}, 32'h0);
      if (d == 4) chk("t1_s_hold", {24'b0, s0}, 32'h20);
      if (d == 5) begin #1 req = '0; end
    end
    chk("t1_ack_lat_g2", a0, 5);
    chk("t1_ack_lat_g1", a1, 4);

    // All four requesters held: round-robin order.
    do_reset();
    nxt();
    req = 4'b1111; op = 4'b1010; idx = 12'(($urandom));
    got.delete();
    for (int n = 0; n < 80 && got.size() < 5; n++) begin
      @(negedge sysclk);
      if (ack0 != 4'b0) got.push_back(oh2i(ack0));
    end
    #1 req = '0;
    chk("t2_nacks", got.size(), 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("t2_ack%0d", i), (got.size() > i) ? got[i] : -1, i % 4);
    repeat (8) nxt();

    // clear_all wins over a simultaneous request.
    do_reset();
    nxt();
    clear_all = 1'b1; req = 4'b0010; op = 4'b0010; idx = 12'h018;
    t0 = cyc; fin = 1'b0;
    order.delete();
    for (int n = 0; n < 60 && !fin; n++) begin
      @(negedge sysclk);
      d = cyc - t0;
      if (d == 2) begin
        chk("t3_r_all", {24'b0, r0}, 32'hFF);
        chk("t3_g_all", {24'b0, g0}, 32'hFF);
        chk("t3_s_none", {24'b0, s0}, 32'h0);
      end
      if (cd0) order.push_back(4);
      if (ack0 != 4'b0) order.push_back(oh2i(ack0));
      #1;
      if (cd0) clear_all = 1'b0;
      if (ack0[1]) begin req = '0; fin = 1'b1; end
    end
    chk("t3_first_clr", (order.size() > 0) ? order[0] : -1, 4);
    chk("t3_then_req1", (order.size() > 1) ? order[1] : -1, 1);
    repeat (8) nxt();

    // Request withdrawn mid-operation still completes.
    do_reset();
    nxt();
    req = 4'b0100; op = 4'b0000; idx = 12'h0C0;
    t0 = cyc;
    for (int n = 0; n < 7; n++) begin
      @(negedge sysclk);
      d = cyc - t0;
      if (d == 1) chk("t4_r_setup", {24'b0, r0}, 32'h08);
      if (d == 5) chk("t4_ack", {28'b0, ack0}, 32'h4);
      if (d == 2) begin #1 req = '0; end
    end

    // Reset in GATE: gate drops at once, no ack, pointer back to 0.
    do_reset();
    nxt();
    req = 4'b0010; op = 4'b0010; idx = 12'h038;
    t0 = cyc;
    for (int n = 0; n < 2; n++) @(negedge sysclk);
    chk("t5_g_before", {24'b0, g0}, 32'h80);
    #1 sys_rst_n = 1'b0;
    req = '0;
    #1;
    chk("t5_g_rst_g2", {24'b0, g0}, 32'h0);
    chk("t5_g_rst_g1", {24'b0, g1}, 32'h0);
    repeat (2) nxt();
    sys_rst_n = 1'b1;
    na = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge sysclk);
      if (ack0 != 4'b0 || ack1 != 4'b0) na++;
    end
    chk("t5_no_ack", na, 0);
    #1 req = 4'b1111;
    a0 = -1;
    for (int n = 0; n < 20 && a0 < 0; n++) begin
      @(negedge sysclk);
      if (ack0 != 4'b0) a0 = oh2i(ack0);
    end
    #1 req = '0;
    chk("t5_ptr_reset", a0, 0);
    repeat (8) nxt();

    // Random traffic with sporadic asynchronous resets.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      nxt();
      if ($urandom_range(0, 3) == 0) begin
        req = 4'($urandom);
        op = 4'($urandom);
        idx = 12'($urandom);
        clear_all = ($urandom_range(0, 15) == 0);
      end
      if ($urandom_range(0, 199) == 0) begin
        #2 sys_rst_n = 1'b0;
        nxt();
        sys_rst_n = 1'b1;
      end
    end
    req = '0;
    clear_all = 1'b0;
    repeat (10) nxt();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
